// File: rtl/xmodem_sender.sv
// XMODEM (checksum) transmitter: packs a 32-bit word stream into blocks, frames them
// for the UART TX byte port and retries on NAK/timeout until ACK, CAN or the retry limit.
module xmodem_sender #(
    parameter int BLOCK_SIZE     = 128,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int MAX_RETRY      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    input  logic        word_last,
    output logic        word_ready,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  block_num
);
    localparam int WORDS = BLOCK_SIZE / 4;
    localparam int WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BIW   = $clog2(BLOCK_SIZE);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW    = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [7:0] SOH = 8'h01;
    localparam logic [7:0] EOT = 8'h04;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam logic [7:0] CAN = 8'h18;

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_WAIT_NAK, S_SEND_HDR, S_SEND_DATA, S_SEND_CSUM,
        S_WAIT_RESP, S_SEND_EOT, S_WAIT_EOT_ACK, S_DONE, S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [BIW-1:0]  idx_q, idx_d;
    logic [WIW-1:0]  widx_q, widx_d;
    logic [7:0]      csum_q, csum_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            tx_dv_q, tx_dv_d;
    logic            out_q, out_d;
    logic [7:0]      blk_q, blk_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            first_q, first_d;
    logic            end_q, end_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [31:0]     buf_q [WORDS];
    logic [31:0]     buf_d [WORDS];

    logic            fail;
    logic [31:0]     cur_word;
    logic [7:0]      data_byte;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        widx_d    = widx_q;
        csum_d    = csum_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        out_d     = out_q;
        blk_d     = blk_q;
        retry_d   = retry_q;
        first_d   = first_q;
        end_d     = end_q;
        timer_d   = timer_q;
        buf_d     = buf_q;
        fail      = 1'b0;
        cur_word  = '0;
        data_byte = '0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_FILL;
                    blk_d   = 8'd1;
                    retry_d = '0;
                    first_d = 1'b1;
                    end_d   = 1'b0;
                    widx_d  = '0;
                    out_d   = 1'b0;
                end
            end
            S_FILL: begin
                if (word_valid) begin
                    buf_d[widx_q] = word_data;
                    if (word_last || widx_q == WIW'(WORDS - 1)) begin
                        // Short final block: zero the slots the stream never reached
                        for (int j = 0; j < WORDS; j++) begin
                            if (j > int'(widx_q)) buf_d[j] = '0;
                        end
                        end_d   = word_last;
                        widx_d  = '0;
                        idx_d   = '0;
                        state_d = first_q ? S_WAIT_NAK : S_SEND_HDR;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end
            S_WAIT_NAK: begin
                if (rx_dv && rx_byte == NAK) begin
                    state_d = S_SEND_HDR;
                    idx_d   = '0;
                end
            end
            S_SEND_HDR, S_SEND_DATA, S_SEND_CSUM, S_SEND_EOT: begin
                if (out_q && tx_done) begin
                    out_d = 1'b0;
                    case (state_q)
                        S_SEND_HDR: begin
                            if (idx_q == BIW'(2)) begin
                                state_d = S_SEND_DATA;
                                idx_d   = '0;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end
                        S_SEND_DATA: begin
                            if (idx_q == BIW'(BLOCK_SIZE - 1)) begin
                                state_d = S_SEND_CSUM;
                                idx_d   = '0;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end
                        S_SEND_CSUM: state_d = S_WAIT_RESP;
                        default:     state_d = S_WAIT_EOT_ACK;
                    endcase
                end
            end
            S_WAIT_RESP, S_WAIT_EOT_ACK: begin
                // A received byte wins over a timeout expiring in the same cycle
                if (rx_dv) begin
                    if (rx_byte == ACK) begin
                        retry_d = '0;
                        first_d = 1'b0;
                        if (state_q == S_WAIT_EOT_ACK) begin
                            state_d = S_DONE;
                        end else if (end_q) begin
                            state_d = S_SEND_EOT;
                        end else begin
                            blk_d   = blk_q + 8'd1;
                            widx_d  = '0;
                            state_d = S_FILL;
                        end
                    end else if (rx_byte == NAK) begin
                        fail = 1'b1;
                    end else if (rx_byte == CAN) begin
                        state_d = S_ERROR;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fail = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (fail) begin
                    if (int'(retry_q) >= MAX_RETRY) begin
                        state_d = S_ERROR;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        idx_d   = '0;
                        state_d = (state_q == S_WAIT_RESP) ? S_SEND_HDR : S_SEND_EOT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) timer_d = '0;

        // Issue the next byte in the same cycle tx_done is consumed (tx_dv is registered)
        cur_word = buf_d[idx_d[BIW-1:2]];
        case (idx_d[1:0])
            2'd0:    data_byte = cur_word[7:0];
            2'd1:    data_byte = cur_word[15:8];
            2'd2:    data_byte = cur_word[23:16];
            default: data_byte = cur_word[31:24];
        endcase
        if (!out_d) begin
            case (state_d)
                S_SEND_HDR: begin
                    tx_dv_d = 1'b1;
                    out_d   = 1'b1;
                    if (idx_d == BIW'(0)) begin
                        tx_byte_d = SOH;
                        csum_d    = '0;
                    end else if (idx_d == BIW'(1)) begin
                        tx_byte_d = blk_d;
                    end else begin
                        tx_byte_d = ~blk_d;
                    end
                end
                S_SEND_DATA: begin
                    tx_dv_d   = 1'b1;
                    out_d     = 1'b1;
                    tx_byte_d = data_byte;
                    csum_d    = csum_q + data_byte;
                end
                S_SEND_CSUM: begin
                    tx_dv_d   = 1'b1;
                    out_d     = 1'b1;
                    tx_byte_d = csum_q;
                end
                S_SEND_EOT: begin
                    tx_dv_d   = 1'b1;
                    out_d     = 1'b1;
                    tx_byte_d = EOT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            widx_q    <= '0;
            csum_q    <= '0;
            tx_byte_q <= '0;
            tx_dv_q   <= 1'b0;
            out_q     <= 1'b0;
            blk_q     <= '0;
            retry_q   <= '0;
            first_q   <= 1'b0;
            end_q     <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            widx_q    <= widx_d;
            csum_q    <= csum_d;
            tx_byte_q <= tx_byte_d;
            tx_dv_q   <= tx_dv_d;
            out_q     <= out_d;
            blk_q     <= blk_d;
            retry_q   <= retry_d;
            first_q   <= first_d;
            end_q     <= end_d;
            timer_q   <= timer_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign word_ready = (state_q == S_FILL);
    assign tx_dv      = tx_dv_q;
    assign tx_byte    = tx_byte_q;
    assign busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign block_num  = blk_q;
endmodule

// File: tb/tb_xmodem_sender.sv
// Directed and randomized bench for xmodem_sender with a queue-based frame model and a UART TX responder.
module tb_xmodem_sender;
    localparam int BS  = 128;
    localparam int WPB = BS / 4;
    localparam int TO  = 300;
    localparam int MR  = 2;

    logic        clk = 1'b0;
    logic        rst_n, start, word_valid, word_last, word_ready;
    logic [31:0] word_data;
    logic        tx_dv, tx_done, rx_dv, busy, done, error;
    logic [7:0]  tx_byte, rx_byte, block_num;

    always #5 clk = ~clk;

    xmodem_sender #(.BLOCK_SIZE(BS), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_done(tx_done),
        .rx_dv(rx_dv), .rx_byte(rx_byte),
        .busy(busy), .done(done), .error(error), .block_num(block_num)
    );

    int         ntests = 0;
    int         nfail  = 0;
    int         hs_err = 0;
    int         wr_cnt = 0;
    int         rd     = 0;
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];

    // UART TX stand-in: captures each byte, checks hold/pulse rules, answers after 0..3 cycles
    initial begin
        tx_done = 1'b0;
        forever begin
            if (tx_dv === 1'b1 && rst_n === 1'b1) begin
                logic [7:0] b;
                int         d;
                bit         ab;
                b  = tx_byte;
                ab = 1'b0;
                cap.push_back(b);
                d = $urandom_range(0, 3);
                repeat (d) begin
                    @(negedge clk);
                    if (!rst_n) ab = 1'b1;
                    else if (!ab && (tx_dv !== 1'b0 || tx_byte !== b)) hs_err++;
                end
                if (!ab) begin
                    tx_done = 1'b1;
                    @(negedge clk);
                    tx_done = 1'b0;
                end else begin
                    @(negedge clk);
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    always @(negedge clk) if (word_ready === 1'b1) wr_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void mk_frame(input logic [7:0] n, input logic [31:0] w[$]);
        int          s;
        logic [31:0] x;
        logic [7:0]  y;
        s = 0;
        exp_q.delete();
        exp_q.push_back(8'h01);
        exp_q.push_back(n);
        exp_q.push_back(8'hFF - n);
        for (int i = 0; i < WPB; i++) begin
            x = (i < w.size()) ? w[i] : 32'h0;
            for (int k = 0; k < 4; k++) begin
                y = 8'((x >> (8 * k)) & 32'hFF);
                exp_q.push_back(y);
                s = s + int'(y);
            end
        end
        exp_q.push_back(8'(s % 256));
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; word_valid = 1'b0; word_last = 1'b0;
        word_data = '0; rx_dv = 1'b0; rx_byte = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cap.delete();
        rd = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic feed(input logic [31:0] w[$], input bit last_at_end, input string tag);
        int t;
        for (int i = 0; i < w.size(); i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            word_valid = 1'b1;
            word_data  = w[i];
            word_last  = last_at_end && (i == w.size() - 1);
            t = 0;
            while (word_ready !== 1'b1 && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 1000) begin
                chk({tag, "_accept_timeout"}, 32'(t), 32'd0);
                word_valid = 1'b0;
                return;
            end
            @(negedge clk);
            word_valid = 1'b0;
            word_last  = 1'b0;
        end
    endtask

    // Waits for exp_q.size() bytes and compares them against exp_q
    task automatic get_frame(input string tag);
        int t, n, m;
        n = exp_q.size();
        t = 0;
        while (cap.size() < rd + n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (cap.size() < rd + n) begin
            chk({tag, "_byte_count"}, 32'(cap.size() - rd), 32'(n));
            rd = cap.size();
            return;
        end
        m = -1;
        for (int i = 0; i < n; i++) begin
            if (m < 0 && cap[rd + i] !== exp_q[i]) begin
                m = i;
                $display("[TB] %s byte %0d got %h want %h", tag, i, cap[rd + i], exp_q[i]);
            end
        end
        chk({tag, "_first_bad_byte"}, 32'(m), 32'hFFFF_FFFF);
        rd = rd + n;
        repeat (8) @(negedge clk);
    endtask

    task automatic expect_eot(input string tag);
        exp_q.delete();
        exp_q.push_back(8'h04);
        get_frame(tag);
    endtask

    // Full transfer; nak_mode adds one NAK-triggered resend per block
    task automatic run_image(input logic [31:0] img[$], input bit nak_mode, input string tag);
        int          nb;
        logic [31:0] blk[$];
        nb = (img.size() + WPB - 1) / WPB;
        pulse_start();
        for (int b = 0; b < nb; b++) begin
            blk.delete();
            for (int i = b * WPB; i < img.size() && i < (b + 1) * WPB; i++) blk.push_back(img[i]);
            feed(blk, b == nb - 1, tag);
            if (b == 0) begin
                repeat (2) @(negedge clk);
                rx(8'h15);
            end
            mk_frame(8'(b + 1), blk);
            get_frame($sformatf("%s_blk%0d", tag, b + 1));
            chk($sformatf("%s_block_num%0d", tag, b + 1), 32'(block_num), 32'((b + 1) % 256));
            if (nak_mode) begin
                rx(8'h15);
                get_frame($sformatf("%s_blk%0d_resend", tag, b + 1));
            end
            rx(8'h06);
        end
        expect_eot({tag, "_eot"});
        rx(8'h06);
        repeat (2) @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] img[$];
        int          n0, t, wr0;

        do_reset();
        chk("rst_word_ready", 32'(word_ready), 0);
        chk("rst_tx_dv", 32'(tx_dv), 0);
        chk("rst_tx_byte", 32'(tx_byte), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done_error", {30'd0, done, error}, 0);
        chk("rst_block_num", 32'(block_num), 0);

        // Single one-word block, with the well-known checksum 0x0A
        img = '{32'h04030201};
        run_image(img, 1'b0, "single");
        chk("single_csum", 32'(cap[WPB * 4 + 3]), 32'h0A);

        // 33 words: second block carries a lone 0x20 word
        do_reset();
        img.delete();
        for (int i = 0; i <= 32; i++) img.push_back(32'(i));
        run_image(img, 1'b0, "two");
        chk("two_blk2_hdr", {8'd0, cap[132], cap[133], cap[134]}, 32'h0001_02FD);
        chk("two_blk2_csum", 32'(cap[263]), 32'h20);

        // Exactly one full block: EOT must follow the first ACK directly
        do_reset();
        img.delete();
        for (int i = 0; i < WPB; i++) img.push_back($urandom);
        run_image(img, 1'b0, "full");

        // NAK twice then ACK: three identical frames, no stream reads meanwhile
        do_reset();
        img = '{$urandom};
        pulse_start();
        feed(img, 1'b1, "nak");
        repeat (2) @(negedge clk);
        rx(8'h15);
        mk_frame(8'd1, img);
        get_frame("nak_f1");
        wr0 = wr_cnt;
        rx(8'h15);
        get_frame("nak_f2");
        rx(8'h15);
        get_frame("nak_f3");
        chk("nak_word_ready_quiet", 32'(wr_cnt - wr0), 0);
        rx(8'h06);
        expect_eot("nak_eot");
        rx(8'h06);
        repeat (2) @(negedge clk);
        chk("nak_done", 32'(done), 1);

        // CAN aborts; a later start clears error and restarts at block 1
        do_reset();
        img = '{$urandom, $urandom};
        pulse_start();
        feed(img, 1'b1, "can");
        repeat (2) @(negedge clk);
        rx(8'h15);
        mk_frame(8'd1, img);
        get_frame("can_f1");
        rx(8'h18);
        repeat (2) @(negedge clk);
        chk("can_error", 32'(error), 1);
        chk("can_busy", 32'(busy), 0);
        n0 = cap.size();
        repeat (50) @(negedge clk);
        chk("can_no_tx", 32'(cap.size()), 32'(n0));
        pulse_start();
        chk("can_restart_error", 32'(error), 0);
        chk("can_restart_busy", 32'(busy), 1);
        chk("can_restart_blk", 32'(block_num), 1);

        // Silence: initial frame plus MR resends, then error
        do_reset();
        img = '{$urandom};
        pulse_start();
        feed(img, 1'b1, "tmo");
        repeat (2) @(negedge clk);
        rx(8'h15);
        mk_frame(8'd1, img);
        for (int k = 0; k <= MR; k++) get_frame($sformatf("tmo_f%0d", k + 1));
        t = 0;
        while (error !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_error", 32'(error), 1);
        chk("tmo_frame_total", 32'(cap.size()), 32'((MR + 1) * (BS + 4)));

        // Asynchronous reset in the middle of the data bytes
        do_reset();
        img = '{$urandom, $urandom, $urandom};
        pulse_start();
        feed(img, 1'b1, "arst");
        repeat (2) @(negedge clk);
        rx(8'h15);
        t = 0;
        while (cap.size() < 20 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs", {busy, done, error, word_ready, tx_dv, 3'd0, tx_byte, block_num, 8'd0},
            32'd0);
        chk("arst_busy", 32'(busy), 0);

        // Randomized images, some with NAK resends
        for (int r = 0; r < 3; r++) begin
            do_reset();
            img.delete();
            n0 = $urandom_range(1, 80);
            for (int i = 0; i < n0; i++) img.push_back($urandom);
            run_image(img, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        chk("handshake_violations", 32'(hs_err), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/xmodem_sender.md
Name: xmodem_sender

Overview:
- Synthesizable XMODEM (checksum variant) transmit engine that sits directly upstream of the UART transmitter.
- Accepts a 32-bit word stream from a loader source and packs it into 128-byte blocks. Drives the UART TX byte handshake and consumes UART RX bytes for ACK/NAK/CAN flow control.
- Used to push program images into a target loader over the serial link.

Parameters:
- BLOCK_SIZE, 128, data bytes per block; must be a multiple of 4.
- TIMEOUT_CYCLES, 2000000, clk cycles to wait for a response before retrying.
- MAX_RETRY, 10, retransmissions allowed per block or EOT before error.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a transfer from IDLE, ignored otherwise
- word_valid  input  1  stream word available
- word_data  input  32  stream word, sent LSB byte first
- word_last  input  1  qualifies final word of image
- word_ready  output  1  word accepted when valid&ready
- tx_dv  output  1  one-cycle byte request to UART TX
- tx_byte  output  8  byte to send, held from tx_dv until tx_done
- tx_done  input  1  UART TX byte-complete pulse
- rx_dv  input  1  UART RX byte-valid pulse
- rx_byte  input  8  received byte
- busy  output  1  high in all states except IDLE, DONE and ERROR
- done  output  1  level, set on EOT ACK; cleared by start or reset
- error  output  1  level, set on abort; cleared by start or reset
- block_num  output  8  current block number

Behaviour:
- Reset (async, rst_n=0): state IDLE; outputs word_ready, tx_dv, busy, done and error are 0; tx_byte=0; block_num=0; buffer contents don't-care.
- Internal block buffer: BLOCK_SIZE/4 words. Retransmission resends from the buffer; the stream is never re-read.
- States and transitions:
  - IDLE: start -> block_num=1, retry=0, clear done/error -> FILL.
  - FILL: word_ready=1 until BLOCK_SIZE/4 words are stored or word_last is accepted. Remaining slots are zero-padded. First block -> WAIT_NAK; later blocks -> SEND_HDR.
  - WAIT_NAK: wait for rx byte 0x15. Other bytes are ignored. No timeout in this state.
  - SEND_HDR: send 0x01, then block_num, then ~block_num.
  - SEND_DATA: send BLOCK_SIZE bytes in word order, byte0=word[7:0]. Accumulate 8-bit checksum, mod 256 wrap. Checksum is reset at each (re)send.
  - SEND_CSUM: send checksum -> WAIT_RESP.
  - WAIT_RESP:
    - 0x06 -> retry=0. If image ended -> SEND_EOT; else block_num+1 (wraps 0xFF->0x00) -> FILL.
    - 0x15 or timeout -> retry+1. If retry exceeds MAX_RETRY -> ERROR; else -> SEND_HDR (same block).
    - 0x18 -> ERROR.
    - Other bytes are ignored.
  - SEND_EOT: send 0x04 -> WAIT_EOT_ACK.
  - WAIT_EOT_ACK:
    - 0x06 -> DONE.
    - 0x15 or timeout -> resend EOT under the same retry limit.
    - 0x18 -> ERROR.
  - DONE / ERROR: hold; start -> same as from IDLE.
- Byte handshake:
  - tx_dv is pulsed for exactly 1 cycle per byte.
  - The next tx_dv is issued no earlier than the cycle after tx_done.
  - Latency from tx_done to the next tx_dv is 1 cycle.
  - A tx_done arriving while no byte is outstanding is ignored.
- RX handling:
  - rx_dv pulses are sampled only in the WAIT_* states; bytes received while sending are dropped.
  - The timeout counter starts on entry to WAIT_RESP or WAIT_EOT_ACK and clears on any state exit.
- Image end at a block boundary: word_last on the final word of a full block means that block is sent, then EOT. No empty padded block is sent.
- rx_dv and timeout expiring in the same cycle: rx_byte takes priority.
- start while busy is ignored.
- Reset mid-transfer aborts immediately, with no EOT or CAN sent.

Test Plan:
- Single block: start, 1 word 0x04030201 with last, then NAK → bytes 01 01 FE 01 02 03 04, 124×00, checksum 0A. After ACK: EOT 04; after ACK: done=1, busy=0.
- Two blocks: 33 words 0x00000000..0x00000020, last on word 33 → block 1 then block 2 (header 01 02 FD), data 20 00 00 00 plus 124 zero bytes, checksum 0x20, then EOT.
- Exactly 32 words with last on word 32 → one block, then EOT immediately after ACK; no second block.
- NAK retry: reply NAK to block 1 twice, then ACK → three identical block-1 frames with identical checksum; word_ready stays 0 during the retries.
- CAN 0x18 during WAIT_RESP → error=1, busy=0, no further tx_dv. A later start clears error.
- Timeout with MAX_RETRY=2 and no responses → 3 block frames, then error=1. Separately, rst_n=0 in the middle of SEND_DATA → all outputs at reset values asynchronously.
